// File: rtl/link_arb_pkg.sv
// Shared types and helpers for the NoC link arbiter and any other
// round-robin scheduler on the NoC side.
package link_arb_pkg;

    // Burst beat counter width; MAX_BURST is capped at 255 to fit it.
    localparam int BEAT_CNT_W   = 8;

    // rr_next works on a fixed-width request vector so it can be shared
    // by every instance; callers zero-extend their request/last values.
    localparam int RR_MAX_PORTS = 16;
    localparam int RR_IDX_W     = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // First requesting port strictly after 'last', wrapping modulo nports.
    // Returns 'last' when nothing requests; callers qualify with |req.
    function automatic logic [RR_IDX_W-1:0] rr_next(
        input logic [RR_MAX_PORTS-1:0] req,
        input logic [RR_IDX_W-1:0]     last,
        input int                      nports
    );
        logic [RR_IDX_W-1:0] pick;
        logic                found;
        int                  idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= RR_MAX_PORTS; k++) begin
            idx = (int'(last) + k) % nports;
            if (k <= nports && !found && req[idx[RR_IDX_W-1:0]]) begin
                pick  = idx[RR_IDX_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotates the request vector against the
// previous winner and priority-encodes the first requester after it.
module rr_pick
    import link_arb_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    localparam int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    last,
    output logic                 vld,
    output logic [PORT_W-1:0]    idx
);

    // Winner index is only meaningful when some port requests.
    always_comb begin
        vld = |req;
        idx = PORT_W'(rr_next(RR_MAX_PORTS'(req), RR_IDX_W'(last), NUM_PORTS));
    end

endmodule

// File: rtl/noc_link_arbiter.sv
// Round-robin, burst-locked arbiter sharing one NoC link between
// NUM_PORTS streams. One registered output slot with valid/ready.
// Optional macro ARB_STALL_CNT_EN adds stall/starvation counters.
module noc_link_arbiter
    import link_arb_pkg::*;
#(
    parameter  int NUM_PORTS  = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int MAX_BURST  = 16,
    localparam int PORT_W     = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] d_a,
    input  logic [NUM_PORTS-1:0]            vld_a,
    output logic [NUM_PORTS-1:0]            rdy_a,
    output logic [DATA_WIDTH-1:0]           d_b,
    output logic [PORT_W-1:0]               port_b,
    output logic                            vld_b,
    input  logic                            rdy_b,
    input  logic                            arb_en,
    output logic                            busy
`ifdef ARB_STALL_CNT_EN
    ,
    output logic [31:0]                     stall_cnt,
    output logic [31:0]                     starve_cnt
`endif
);

    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(MAX_BURST - 1);

    arb_state_t              state;
    logic [PORT_W-1:0]       last_grant;   // doubles as the current grantee
    logic [BEAT_CNT_W-1:0]   beat_cnt;
    logic                    slot_free;
    logic                    in_xfer;
    logic                    out_xfer;
    logic                    last_beat;
    logic                    pick_vld;
    logic [PORT_W-1:0]       pick_idx;
    logic [DATA_WIDTH-1:0]   grant_data;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_pick (
        .req  (vld_a),
        .last (last_grant),
        .vld  (pick_vld),
        .idx  (pick_idx)
    );

    assign slot_free  = !vld_b || rdy_b;
    assign out_xfer   = vld_b && rdy_b;
    assign in_xfer    = |(vld_a & rdy_a);
    assign last_beat  = (beat_cnt == LAST_BEAT);
    assign grant_data = d_a[int'(last_grant)*DATA_WIDTH +: DATA_WIDTH];
    assign busy       = (state == GRANT) || vld_b;

    // Ready goes only to the grantee and only when the slot can take a beat;
    // it never looks at vld_a, so no valid->ready loop exists.
    always_comb begin
        rdy_a = '0;
        if (reset_n && state == GRANT && slot_free)
            rdy_a[last_grant] = 1'b1;
    end

    // Output slot: load on input transfer, otherwise drain on output transfer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_b  <= 1'b0;
            d_b    <= '0;
            port_b <= '0;
        end else if (in_xfer) begin
            vld_b  <= 1'b1;
            d_b    <= grant_data;
            port_b <= last_grant;
        end else if (out_xfer) begin
            vld_b  <= 1'b0;
        end
    end

    // Grant FSM: one IDLE cycle per arbitration, burst ends at the beat
    // limit or as soon as the grantee has nothing to offer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= PORT_W'(NUM_PORTS - 1);
            beat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_en && pick_vld) begin
                        last_grant <= pick_idx;
                        beat_cnt   <= '0;
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    if (in_xfer) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end else if (slot_free && !vld_a[last_grant]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_STALL_CNT_EN
    logic [NUM_PORTS-1:0] grant_oh;
    logic                 starve;

    always_comb begin
        grant_oh             = '0;
        grant_oh[last_grant] = 1'b1;
    end

    assign starve = (state == GRANT) && |(vld_a & ~grant_oh);

    // Saturating event counters, frozen while arbitration is disabled.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt  <= '0;
            starve_cnt <= '0;
        end else if (arb_en) begin
            if (vld_b && !rdy_b && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (starve && starve_cnt != '1)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end
`endif

    // Structural invariants.
    a_rdy_onehot: assert property (@(posedge clk) $onehot0(rdy_a));
    a_beat_bound: assert property (@(posedge clk) disable iff (!reset_n)
                                   beat_cnt <= LAST_BEAT);
    a_slot_hold:  assert property (@(posedge clk) disable iff (!reset_n)
                                   vld_b && !rdy_b |=> $stable(d_b) && $stable(port_b));

endmodule

// File: tb/tb_noc_link_arbiter.sv
// Directed bench for noc_link_arbiter: per-port sources emit words
// (port<<16 | n), every output transfer is logged and checked.
module tb_noc_link_arbiter;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int MB = 16;
    localparam int PW = 2;

    logic                 clk     = 1'b0;
    logic                 reset_n = 1'b0;
    logic [NP*DW-1:0]     d_a     = '0;
    logic [NP-1:0]        vld_a   = '0;
    logic [NP-1:0]        rdy_a;
    logic [DW-1:0]        d_b;
    logic [PW-1:0]        port_b;
    logic                 vld_b;
    logic                 rdy_b   = 1'b1;
    logic                 arb_en  = 1'b1;
    logic                 busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int cnt[NP];
    int lim[NP];
    logic [NP-1:0] pend = '0;
    int oq_port[$];
    int oq_data[$];
    int oq_cyc[$];
    int base;

    always #5 clk = ~clk;

    noc_link_arbiter #(
        .NUM_PORTS  (NP),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .d_a     (d_a),
        .vld_a   (vld_a),
        .rdy_a   (rdy_a),
        .d_b     (d_b),
        .port_b  (port_b),
        .vld_b   (vld_b),
        .rdy_b   (rdy_b),
        .arb_en  (arb_en),
        .busy    (busy)
    );

    // sample handshakes mid-cycle; log output transfers
    always @(negedge clk) begin
        pend = vld_a & rdy_a;
        if (reset_n && vld_b && rdy_b) begin
            oq_port.push_back(int'(port_b));
            oq_data.push_back(int'(d_b));
            oq_cyc.push_back(cyc);
        end
    end

    // source model: advance on accepted beats, drive next word
    always @(posedge clk) begin
        cyc++;
        #1;
        for (int p = 0; p < NP; p++) begin
            if (!reset_n) cnt[p] = 1;
            else if (pend[p]) cnt[p] = cnt[p] + 1;
            vld_a[p] = (cnt[p] <= lim[p]);
            d_a[p*DW +: DW] = DW'((p << 16) | cnt[p]);
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int idx, input int p, input int w);
        logic [63:0] a;
        if (idx < oq_data.size()) a = {32'(oq_port[idx]), 32'(oq_data[idx])};
        else                      a = 64'hdead_dead_dead_dead;
        chk(tag, a, {32'(p), 32'((p << 16) | w)});
    endtask

    task automatic chk_gap(input string tag, input int idx, input int exp);
        int g;
        g = (idx < oq_cyc.size() && idx > 0) ? oq_cyc[idx] - oq_cyc[idx-1] : -1;
        chk(tag, 64'(g), 64'(exp));
    endtask

    task automatic wait_outs(input int b, input int n, input string tag);
        int t = 0;
        while (oq_data.size() < b + n && t < 500) begin
            @(posedge clk);
            t++;
        end
        if (t >= 500) chk(tag, 64'(oq_data.size() - b), 64'(n));
    endtask

    task automatic do_reset(input int l0, input int l1, input int l2, input int l3);
        @(posedge clk); #2;
        reset_n = 1'b0;
        rdy_b   = 1'b1;
        arb_en  = 1'b1;
        lim[0] = l0; lim[1] = l1; lim[2] = l2; lim[3] = l3;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        base = oq_data.size();
    endtask

    initial begin
        for (int p = 0; p < NP; p++) lim[p] = 0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vld_b", 64'(vld_b), 0);
        chk("rst_rdy_a", 64'(rdy_a), 0);
        chk("rst_busy",  64'(busy), 0);
        chk("rst_d_b",   64'(d_b), 0);
        chk("rst_port_b", 64'(port_b), 0);

        // port 0 alone, 20 words: 16 back-to-back, bubble, 4 more
        do_reset(20, 0, 0, 0);
        wait_outs(base, 20, "t1_timeout");
        for (int k = 0; k < 20; k++) chk_out("t1_beat", base + k, 0, k + 1);
        for (int k = 1; k < 20; k++) chk_gap("t1_gap", base + k, (k == 16) ? 2 : 1);

        // ports 0 and 1 always valid: alternating 16-beat bursts
        do_reset(40, 40, 0, 0);
        wait_outs(base, 48, "t2_timeout");
        for (int k = 0; k < 48; k++)
            chk_out("t2_beat", base + k, (k / 16) % 2, (k < 16) ? k + 1 : k - 15);
        for (int k = 1; k < 48; k++)
            chk_gap("t2_gap", base + k, (k == 16 || k == 32) ? 2 : 1);

        // 5-cycle output stall mid-burst; word 7 sits in the slot
        do_reset(20, 0, 0, 0);
        wait_outs(base, 6, "t3_timeout");
        #2 rdy_b = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("t3_hold_vld", 64'(vld_b), 1);
            chk("t3_hold_d",   64'(d_b), 7);
            chk("t3_hold_p",   64'(port_b), 0);
            chk("t3_rdy_a",    64'(rdy_a), 0);
            @(posedge clk);
        end
        #2 rdy_b = 1'b1;
        wait_outs(base, 20, "t3_timeout2");
        for (int k = 0; k < 20; k++) chk_out("t3_beat", base + k, 0, k + 1);
        chk_gap("t3_burst_gap", base + 16, 2);

        // port 2 runs dry after 3 beats, port 3 takes over
        do_reset(0, 0, 3, 5);
        wait_outs(base, 8, "t4_timeout");
        for (int k = 0; k < 3; k++) chk_out("t4_p2", base + k, 2, k + 1);
        for (int k = 3; k < 8; k++) chk_out("t4_p3", base + k, 3, k - 2);
        chk_gap("t4_switch_gap", base + 3, 3);

        // arb_en dropped at beat 5: burst finishes, then no new grant
        do_reset(20, 20, 0, 0);
        wait_outs(base, 5, "t5_timeout");
        #2 arb_en = 1'b0;
        wait_outs(base, 16, "t5_timeout2");
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("t5_busy",  64'(busy), 0);
        chk("t5_rdy_a", 64'(rdy_a), 0);
        chk("t5_count", 64'(oq_data.size() - base), 16);
        chk_out("t5_last", base + 15, 0, 16);
        @(posedge clk); #2 arb_en = 1'b1;
        wait_outs(base, 17, "t5_timeout3");
        chk_out("t5_resume", base + 16, 1, 1);

        // reset at beat 8, then port 0 wins first
        do_reset(20, 0, 0, 0);
        wait_outs(base, 8, "t6_timeout");
        #2 reset_n = 1'b0;
        lim[0] = 5;
        lim[1] = 5;
        @(negedge clk);
        chk("t6_rdy_a_async", 64'(rdy_a), 0);
        @(posedge clk);
        @(negedge clk);
        chk("t6_vld_b", 64'(vld_b), 0);
        chk("t6_rdy_a", 64'(rdy_a), 0);
        chk("t6_busy",  64'(busy), 0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        base = oq_data.size();
        wait_outs(base, 6, "t6_timeout2");
        chk_out("t6_first", base, 0, 1);
        chk_out("t6_next",  base + 5, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/noc_link_arbiter.md
Name: noc_link_arbiter

Overview:
- Round-robin, burst-locked arbiter that shares one NoC link (the fifo_hs write side) between NUM_PORTS user streams, each typically coming from an nth_fifo.
- Each grant locks one port for up to MAX_BURST beats; the winning data is registered into a single output slot with valid/ready.
- Sits on the sender clock domain, between the nth_fifo outputs and the fifo_hs d_a/vld_a/rdy_a inputs.

Parameters:
- NUM_PORTS, 4, number of requesters; range 2..16.
- DATA_WIDTH, 32, payload width per port.
- MAX_BURST, 16, maximum beats per grant; range 1..255.
- PORT_W, localparam clog2(NUM_PORTS), source-id width.

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  synchronous, active-low reset.
- d_a  in  NUM_PORTS*DATA_WIDTH  packed inputs; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- vld_a  in  NUM_PORTS  per-port valid.
- rdy_a  out  NUM_PORTS  per-port ready; one-hot or zero.
- d_b  out  DATA_WIDTH  registered output data.
- port_b  out  PORT_W  source port of d_b.
- vld_b  out  1  output valid.
- rdy_b  in  1  link ready (fifo_hs rdy_a).
- arb_en  in  1  when low, no new grants are issued.
- busy  out  1  high when state is GRANT or vld_b is high.

Behaviour:
- Reset (reset_n=0 at posedge) sets:
  - state=IDLE, vld_b=0, d_b=0, port_b=0, beat_cnt=0.
  - last_grant=NUM_PORTS-1, so port 0 has first priority.
  - rdy_a=0 while reset_n is low.
- Reset asserted mid-burst discards any held beat (vld_b=0 next cycle); no partial-burst recovery.
- Transfer conditions:
  - Input transfer on port i: vld_a[i] && rdy_a[i].
  - Output transfer: vld_b && rdy_b.
- Output slot:
  - slot_free = !vld_b || rdy_b.
  - On an input transfer: d_b<=d_a[g], port_b<=g, vld_b<=1.
  - Else on an output transfer: vld_b<=0.
  - d_b and port_b hold stable while vld_b && !rdy_b.
- Input-to-output latency is one cycle. Full throughput is one beat per cycle within a burst.
- rdy_a[i] = (state==GRANT) && (g==i) && slot_free. Combinational from rdy_b; no path from vld_a.
- State IDLE:
  - If arb_en && |vld_a: g <= first port with vld_a set, scanning last_grant+1, last_grant+2, ... modulo NUM_PORTS.
  - On that grant: last_grant<=g, beat_cnt<=0, state<=GRANT.
  - Otherwise stay in IDLE.
  - Rearbitration costs exactly one IDLE cycle (a bubble) between bursts.
- State GRANT:
  - On an input transfer: beat_cnt++.
  - Go to IDLE when an input transfer occurs with beat_cnt==MAX_BURST-1 (burst limit).
  - Also go to IDLE when slot_free && !vld_a[g] (requester ran dry). No grant is held across idle input cycles.
  - arb_en falling during GRANT does not abort the burst; it only blocks the next grant.
- A transfer on the last beat and the release happen in the same cycle; the held beat still drains normally from the output slot.
- beat_cnt width is 8 bits and never exceeds MAX_BURST-1.
- With a single active requester, that port is re-granted after each one-cycle IDLE bubble.

Optional Feature:
- Macro ARB_STALL_CNT_EN.
- When defined, adds these outputs:
  - stall_cnt [31:0]: counts cycles with vld_b && !rdy_b.
  - starve_cnt [31:0]: counts cycles where some vld_a[i] is high, i is not granted, and state==GRANT.
  - Both counters reset to 0, saturate at 2^32-1, and freeze while arb_en is low.
- When not defined, these ports and counters do not exist; the rest of the behaviour is identical.

Decomposition:
- Shared package link_arb_pkg holds:
  - arb_state_t enum {IDLE, GRANT};
  - function rr_next(req, last) returning the next port index;
  - constant BEAT_CNT_W=8.
- One sub-module, rr_pick: combinational rotate/priority-encode of vld_a against last_grant, outputting a valid flag and an index. It is reusable by the NoC-side scheduler.

Test Plan:
- Port 0 alone, 20 words (1..20), rdy_b=1, MAX_BURST=16:
  - words 1..16 appear on consecutive cycles with port_b=0;
  - one bubble cycle;
  - words 17..20 follow.
- Ports 0 and 1 both always valid:
  - output bursts alternate 16 beats from port 0, then 16 from port 1, then port 0;
  - exactly one vld_b gap between bursts;
  - no beats are lost.
- rdy_b held low for 5 cycles mid-burst:
  - d_b and port_b are stable across those cycles;
  - rdy_a is all zero during the stall;
  - the beat count still totals 16 per burst.
- Port 2 drops vld_a after 3 beats while port 3 is valid:
  - port 2 is released after 3 beats;
  - port 3 is granted after one IDLE cycle.
- arb_en deasserted at beat 5 of a burst:
  - the burst completes all 16 beats;
  - the arbiter then stays in IDLE with busy=0 once the slot drains;
  - reasserting arb_en resumes granting at the next port in round-robin order.
- reset_n pulsed low at beat 8:
  - next cycle vld_b=0 and rdy_a=0;
  - after release, port 0 is granted first.
